// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the IF-stage fetch controller
// Contents: if_state_e fetch FSM encoding, IF_RESET_PC default boot vector,
// NOP instruction word used as the cleared IF/ID / skid contents.
package if_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,   // first cycle out of reset, no request yet
        REQ   = 2'd1,   // request outstanding, result is wanted
        FULL  = 2'd2,   // skid holds a word, fetching paused
        DROP  = 2'd3    // request outstanding, result will be discarded
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP         = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry holding register for a fetched word under ID back-pressure
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   load_i                capture instr_i/pcadd4_i, entry becomes valid
//   pop_i                 entry consumed, becomes invalid
//   flush_i               discard entry (wins over load and pop)
//   instr_i, pcadd4_i     word and its PC+4 to capture
//   valid_o, instr_o, pcadd4_o  entry contents
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcadd4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pcadd4_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pcadd4_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            instr_q  <= NOP;
            pcadd4_q <= 32'h0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            instr_q  <= instr_i;
            pcadd4_q <= pcadd4_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign instr_o  = instr_q;
    assign pcadd4_o = pcadd4_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - MIPS III IF stage: PC, imem req/ack handshake, IF/ID register, redirects
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   imem_req/imem_addr (out)          fetch request, held with a stable address until imem_ack
//   imem_ack/imem_rdata (in)          fetch completion and instruction word
//   id_stall (in)                     ID cannot accept, IF/ID holds
//   branch_taken/branch_target (in)   taken branch in ID (delay slot is kept)
//   exc_flush/exc_target (in)         CP0 flush, highest priority, discards everything in flight
//   ifid_valid/ifid_instr/ifid_pcadd4 IF/ID pipeline register
//   fetch_busy (out)                  a fetch is outstanding (REQ or DROP)
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pcadd4,
    output logic        fetch_busy
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_target_q, br_target_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcadd4_q, ifid_pcadd4_d;

    logic        skid_load, skid_pop, skid_flush;
    logic        skid_valid;
    logic [31:0] skid_instr, skid_pcadd4;

    logic [31:0] req_plus4;
    logic        ifid_accept;
    logic        br_ok;

    assign req_plus4   = req_addr_q + 32'd4;
    assign ifid_accept = !ifid_valid_q || !id_stall;
    // branch_taken is only meaningful while ID actually holds and advances an instruction
    assign br_ok       = branch_taken && ifid_valid_q && !id_stall;

    if_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .pop_i    (skid_pop),
        .flush_i  (skid_flush),
        .instr_i  (imem_rdata),
        .pcadd4_i (req_plus4),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pcadd4_o (skid_pcadd4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RESET;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            br_pend_q     <= 1'b0;
            br_target_q   <= 32'h0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP;
            ifid_pcadd4_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            br_pend_q     <= br_pend_d;
            br_target_q   <= br_target_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pcadd4_q <= ifid_pcadd4_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        br_pend_d     = br_pend_q;
        br_target_d   = br_target_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pcadd4_d = ifid_pcadd4_q;
        skid_load     = 1'b0;
        skid_pop      = 1'b0;
        skid_flush    = 1'b0;

        // ID consumed the current entry; a load below may refill it
        if (ifid_valid_q && !id_stall) begin
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            RESET: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    if (ifid_accept) begin
                        ifid_valid_d  = 1'b1;
                        ifid_instr_d  = imem_rdata;
                        ifid_pcadd4_d = req_plus4;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                    // this word was the delay slot of a pending branch
                    pc_d      = br_pend_q ? br_target_q : req_plus4;
                    br_pend_d = 1'b0;
                end
            end
            FULL: begin
                if (!id_stall) begin
                    skid_pop      = 1'b1;
                    ifid_valid_d  = 1'b1;
                    ifid_instr_d  = skid_instr;
                    ifid_pcadd4_d = skid_pcadd4;
                    state_d       = REQ;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = RESET;
        endcase

        if (br_ok) begin
            if (skid_valid) begin
                // delay slot already captured in skid; anything in flight is wrong-path
                pc_d = branch_target;
                if (state_q == REQ && !imem_ack) begin
                    state_d = DROP;
                end
            end else if (state_q == REQ && imem_ack) begin
                // the word arriving now is the delay slot
                pc_d = branch_target;
            end else begin
                br_pend_d   = 1'b1;
                br_target_d = branch_target;
            end
        end

        if (exc_flush) begin
            ifid_valid_d = 1'b0;
            skid_flush   = 1'b1;
            skid_load    = 1'b0;
            skid_pop     = 1'b0;
            br_pend_d    = 1'b0;
            pc_d         = exc_target;
            case (state_q)
                REQ:     state_d = imem_ack ? REQ : DROP;
                FULL:    state_d = REQ;
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end

        // a fresh request starts from the updated pc
        if (state_d == REQ && (state_q != REQ || imem_ack)) begin
            req_addr_d = pc_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DROP);
    assign fetch_busy  = imem_req;
    assign imem_addr   = req_addr_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pcadd4 = ifid_pcadd4_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcadd4;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int wcnt   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exc_flush     (exc_flush),
        .exc_target    (exc_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pcadd4   (ifid_pcadd4),
        .fetch_busy    (fetch_busy)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // memory: acks once the request has waited lat full cycles
    always @(negedge clk) begin
        if (rst_n && imem_req && wcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) wcnt <= 0;
        else                                 wcnt <= wcnt + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ifid_valid && n < 40) begin
            step();
            n++;
        end
        check(name, 32'(ifid_valid), 32'd1);
    endtask

    task automatic wait_addr_change(input logic [31:0] old, input logic no_valid, input string name);
        int   n   = 0;
        logic saw = 1'b0;
        while (imem_addr == old && n < 40) begin
            step();
            n++;
            if (ifid_valid) saw = 1'b1;
        end
        check({name, "_timeout"}, 32'(n < 40), 32'd1);
        if (no_valid) check({name, "_discard"}, 32'(saw), 32'd0);
    endtask

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0004};
        vecs[2] = '{1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0008};
        vecs[3] = '{1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C};
        vecs[4] = '{1'b1, 1'b0, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C};
        vecs[5] = '{1'b1, 1'b0, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C};
        vecs[6] = '{1'b0, 1'b0, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C};
        vecs[7] = '{1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0010};
        vecs[8] = '{1'b0, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_0014};

        rst_n         = 1'b0;
        id_stall      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        exc_flush     = 1'b0;
        exc_target    = 32'h0;
        repeat (3) @(negedge clk);
        #1;

        check("rst_req",    32'(imem_req),   32'd0);
        check("rst_addr",   imem_addr,       32'hBFC0_0000);
        check("rst_busy",   32'(fetch_busy), 32'd0);
        check("rst_valid",  32'(ifid_valid), 32'd0);
        check("rst_instr",  ifid_instr,      32'h0);
        check("rst_pcadd4", ifid_pcadd4,     32'h0);
        rst_n = 1'b1;

        // streaming with zero-wait memory, then a 3-cycle stall into the skid
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("vec%0d_req", i),  32'(imem_req),   32'(vecs[i].exp_req));
            check($sformatf("vec%0d_busy", i), 32'(fetch_busy), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_addr", i), imem_addr,       vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc4", i),   ifid_pcadd4, vecs[i].exp_pc4);
                check($sformatf("vec%0d_instr", i), ifid_instr,  mem_word(vecs[i].exp_pc4 - 32'd4));
            end
            id_stall = vecs[i].stall;
        end

        // flush with an ack in the same cycle, then slow memory for the branch test
        exc_flush  = 1'b1;
        exc_target = 32'h0000_0100;
        lat        = 3;
        step();
        exc_flush = 1'b0;
        check("excack_addr",  imem_addr,       32'h0000_0100);
        check("excack_req",   32'(imem_req),   32'd1);
        check("excack_valid", 32'(ifid_valid), 32'd0);
        wait_valid("br_setup_valid");
        check("br_setup_pc4",  ifid_pcadd4, 32'h0000_0104);
        check("br_setup_addr", imem_addr,   32'h0000_0104);

        // branch at 0x100 while the delay-slot fetch of 0x104 is outstanding
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0400;
        step();
        branch_taken = 1'b0;
        check("br_drain_valid", 32'(ifid_valid), 32'd0);
        check("br_hold_addr",   imem_addr,       32'h0000_0104);
        wait_valid("br_ds_valid");
        check("br_ds_pc4",   ifid_pcadd4, 32'h0000_0108);
        check("br_ds_instr", ifid_instr,  mem_word(32'h0000_0104));
        check("br_tgt_addr", imem_addr,   32'h0000_0400);

        // flush to 0x1FC so that 0x200 is outstanding while 0x1FC sits in IF/ID
        exc_flush  = 1'b1;
        exc_target = 32'h0000_01FC;
        step();
        exc_flush = 1'b0;
        check("drop_valid", 32'(ifid_valid), 32'd0);
        check("drop_addr",  imem_addr,       32'h0000_0400);
        check("drop_req",   32'(imem_req),   32'd1);
        wait_addr_change(32'h0000_0400, 1'b1, "drop_wait");
        check("drop_next_addr", imem_addr, 32'h0000_01FC);
        wait_valid("ew_setup_valid");
        check("ew_setup_addr", imem_addr, 32'h0000_0200);

        // exception while the 0x200 request awaits its ack
        exc_flush  = 1'b1;
        exc_target = 32'h8000_0180;
        step();
        exc_flush = 1'b0;
        check("ew_valid", 32'(ifid_valid), 32'd0);
        check("ew_addr",  imem_addr,       32'h0000_0200);
        wait_addr_change(32'h0000_0200, 1'b1, "ew_wait");
        check("ew_next_addr", imem_addr, 32'h8000_0180);
        wait_valid("ew_vec_valid");
        check("ew_vec_pc4",   ifid_pcadd4, 32'h8000_0184);
        check("ew_vec_instr", ifid_instr,  mem_word(32'h8000_0180));

        // exception and branch together: exception target wins, no pending branch survives
        exc_flush     = 1'b1;
        exc_target    = 32'h0000_1000;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2000;
        step();
        exc_flush    = 1'b0;
        branch_taken = 1'b0;
        check("sim_valid", 32'(ifid_valid), 32'd0);
        wait_addr_change(32'h8000_0184, 1'b1, "sim_wait1");
        check("sim_addr1", imem_addr, 32'h0000_1000);
        wait_addr_change(32'h0000_1000, 1'b0, "sim_wait2");
        check("sim_addr2", imem_addr,   32'h0000_1004);
        check("sim_pc4",   ifid_pcadd4, 32'h0000_1004);

        // address wrap with zero-wait memory
        exc_flush  = 1'b1;
        exc_target = 32'hFFFF_FFFC;
        lat        = 0;
        step();
        exc_flush = 1'b0;
        wait_addr_change(32'h0000_1004, 1'b1, "wrap_wait");
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr1",  imem_addr,       32'h0000_0000);
        check("wrap_valid",  32'(ifid_valid), 32'd1);
        check("wrap_pc4",    ifid_pcadd4,     32'h0000_0000);
        check("wrap_instr",  ifid_instr,      mem_word(32'hFFFF_FFFC));

        // branch while the delay slot is acked in the same cycle
        branch_taken  = 1'b1;
        branch_target = 32'h0000_3000;
        step();
        branch_taken = 1'b0;
        check("brack_pc4",   ifid_pcadd4, 32'h0000_0004);
        check("brack_instr", ifid_instr,  mem_word(32'h0000_0000));
        check("brack_addr",  imem_addr,   32'h0000_3000);
        step();
        check("brack_pc4b",  ifid_pcadd4, 32'h0000_3004);
        check("brack_addrb", imem_addr,   32'h0000_3004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
